// File: rtl/rom_sequencer_if.sv
// Bus bundle between the ROM scan sequencer and its controller/ROM.
// The master side drives the requests and the ROM data; the slave side is the sequencer.
interface rom_sequencer_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
);
  logic                             start;
  logic                             step_mode;
  logic                             step;
  logic                             abort;
  logic [DATA_WIDTH-1:0]            rom_data;
  logic [ADDR_WIDTH-1:0]            rom_addr;
  logic [DATA_WIDTH-1:0]            data_out;
  logic                             data_valid;
  logic [DATA_WIDTH+ADDR_WIDTH-1:0] sum;
  logic                             busy;
  logic                             done;

  modport master (
    output start, step_mode, step, abort, rom_data,
    input  rom_addr, data_out, data_valid, sum, busy, done
  );

  modport slave (
    input  start, step_mode, step, abort, rom_data,
    output rom_addr, data_out, data_valid, sum, busy, done
  );
endinterface

// File: rtl/rom_sequencer.sv
// Scans every ROM address once per start, auto-run or one word per step pulse.
// Optional running checksum of captured words: define ROM_SEQUENCER_CHECKSUM_EN.
module rom_sequencer #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 4
) (
  input logic           clock,
  input logic           reset,
  rom_sequencer_if.slave bus
);
  localparam int SUM_WIDTH = DATA_WIDTH + ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, READ, WAIT, DONE} state_t;

  state_t                state;
  logic                  step_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      step_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= READ;
            addr_q <= '0;
            step_q <= bus.step_mode;
            busy_q <= 1'b1;
          end
        end
        READ: begin
          if (bus.abort) begin
            state  <= IDLE;
            addr_q <= '0;
            busy_q <= 1'b0;
          end else begin
            data_q  <= bus.rom_data;
            valid_q <= 1'b1;
            addr_q  <= addr_q + ADDR_WIDTH'(1);
            if (addr_q == '1) begin
              state  <= DONE;
              busy_q <= 1'b0;
            end else if (step_q) begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.abort) begin
            state  <= IDLE;
            addr_q <= '0;
            busy_q <= 1'b0;
          end else if (bus.step) begin
            state <= READ;
          end
        end
        DONE: begin
          // done is registered, so it shows on the cycle after DONE unless aborted
          state  <= IDLE;
          addr_q <= '0;
          if (!bus.abort) done_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROM_SEQUENCER_CHECKSUM_EN
  logic [SUM_WIDTH-1:0] sum_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else if (state == IDLE && bus.start) begin
      sum_q <= '0;
    end else if (state == READ && !bus.abort) begin
      sum_q <= sum_q + {{ADDR_WIDTH{1'b0}}, bus.rom_data};
    end
  end

  assign bus.sum = sum_q;
`else
  assign bus.sum = '0;
`endif

  assign bus.rom_addr   = addr_q;
  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_rom_sequencer.sv
// Self-checking bench for rom_sequencer: directed scans plus randomized ROM
// contents, modes, abort points and ignored-input noise against a word-level model.
module tb_rom_sequencer;
  localparam int AW = 2;
  localparam int DW = 4;
  localparam int NW = 1 << AW;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  rom_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  rom_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] rom [NW];
  assign bus.rom_data = rom[bus.rom_addr];

  int n_cmp = 0;
  int n_bad = 0;
  int ref_sum;
  int ref_last;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int exp_sum(input int s);
`ifdef ROM_SEQUENCER_CHECKSUM_EN
    return s;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_rom(input bit fixed);
    if (fixed) begin
      rom[0] = 4'h4; rom[1] = 4'hC; rom[2] = 4'h6; rom[3] = 4'h7;
    end else begin
      for (int i = 0; i < NW; i++) rom[i] = DW'($urandom_range(0, (1 << DW) - 1));
    end
  endtask

  task automatic capture(input int i);
    ref_last = int'(rom[i]);
    ref_sum += int'(rom[i]);
  endtask

  task automatic idle_check(input string tag);
    chk({tag, "_busy"},  bus.busy, 0);
    chk({tag, "_done"},  bus.done, 0);
    chk({tag, "_valid"}, bus.data_valid, 0);
    chk({tag, "_addr"},  bus.rom_addr, 0);
    chk({tag, "_data"},  bus.data_out, ref_last);
    chk({tag, "_sum"},   bus.sum, exp_sum(ref_sum));
  endtask

  // abort_at: index of the word whose capture edge is replaced by abort, -1 = none
  task automatic auto_scan(input bit noise, input int abort_at);
    bus.start = 1'b1; bus.step_mode = 1'b0;
    tick();
    bus.start = 1'b0;
    ref_sum = 0;
    chk("auto_start_busy", bus.busy, 1);
    chk("auto_start_addr", bus.rom_addr, 0);
    chk("auto_start_valid", bus.data_valid, 0);
    for (int i = 0; i < NW; i++) begin
      if (noise) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.step  = 1'($urandom_range(0, 1));
      end
      if (i == abort_at) begin
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0; bus.start = 1'b0; bus.step = 1'b0;
        idle_check("abort_auto");
        tick();
        idle_check("abort_auto_after");
        return;
      end
      tick();
      capture(i);
      chk("auto_valid", bus.data_valid, 1);
      chk("auto_data", bus.data_out, ref_last);
      chk("auto_sum", bus.sum, exp_sum(ref_sum));
      chk("auto_addr", bus.rom_addr, (i + 1) % NW);
      chk("auto_busy", bus.busy, (i < NW - 1) ? 1 : 0);
      chk("auto_done_early", bus.done, 0);
    end
    bus.step  = 1'b0;
    bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    bus.start = 1'b0;
    chk("auto_done", bus.done, 1);
    chk("auto_done_valid", bus.data_valid, 0);
    chk("auto_done_busy", bus.busy, 0);
    chk("auto_done_addr", bus.rom_addr, 0);
    chk("auto_done_sum", bus.sum, exp_sum(ref_sum));
    tick();
    chk("auto_done_pulse", bus.done, 0);
    chk("auto_after_busy", bus.busy, 0);
  endtask

  // abort_at: abort while waiting after abort_at words were captured, -1 = none
  task automatic step_scan(input bit noise, input int abort_at);
    int gap;
    bus.start = 1'b1; bus.step_mode = 1'b1;
    tick();
    bus.start = 1'b0; bus.step_mode = 1'b0;
    ref_sum = 0;
    chk("step_start_busy", bus.busy, 1);
    tick();
    capture(0);
    chk("step_valid0", bus.data_valid, 1);
    chk("step_data0", bus.data_out, ref_last);
    chk("step_sum0", bus.sum, exp_sum(ref_sum));
    for (int w = 1; w < NW; w++) begin
      if (w == abort_at) begin
        bus.abort = 1'b1;
        bus.step  = noise ? 1'b1 : 1'b0;
        bus.start = noise ? 1'b1 : 1'b0;
        tick();
        bus.abort = 1'b0; bus.step = 1'b0; bus.start = 1'b0;
        idle_check("abort_wait");
        tick();
        idle_check("abort_wait_after");
        return;
      end
      gap = noise ? int'($urandom_range(1, 5)) : 4;
      repeat (gap) begin
        bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
        chk("step_gap_valid", bus.data_valid, 0);
        chk("step_gap_addr", bus.rom_addr, w);
        chk("step_gap_busy", bus.busy, 1);
        chk("step_gap_data", bus.data_out, ref_last);
      end
      bus.start = 1'b0;
      bus.step  = 1'b1;
      tick();
      bus.step = 1'b0;
      chk("step_read_valid", bus.data_valid, 0);
      tick();
      capture(w);
      chk("step_valid", bus.data_valid, 1);
      chk("step_data", bus.data_out, ref_last);
      chk("step_sum", bus.sum, exp_sum(ref_sum));
      chk("step_busy", bus.busy, (w < NW - 1) ? 1 : 0);
    end
    tick();
    chk("step_done", bus.done, 1);
    chk("step_done_addr", bus.rom_addr, 0);
    tick();
    chk("step_done_pulse", bus.done, 0);
  endtask

  task automatic reset_midscan();
    bus.start = 1'b1; bus.step_mode = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    #2 reset = 1'b1;
    #1;
    ref_sum = 0; ref_last = 0;
    chk("rst_mid_addr", bus.rom_addr, 0);
    chk("rst_mid_data", bus.data_out, 0);
    chk("rst_mid_sum", bus.sum, 0);
    chk("rst_mid_valid", bus.data_valid, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_done", bus.done, 0);
    tick();
    reset = 1'b0;
    repeat (6) begin
      tick();
      chk("rst_after_done", bus.done, 0);
      chk("rst_after_valid", bus.data_valid, 0);
    end
  endtask

  initial begin
    int mode, ab;
    bit nz;
    reset = 1'b1;
    bus.start = 1'b0; bus.step_mode = 1'b0; bus.step = 1'b0; bus.abort = 1'b0;
    load_rom(1'b1);
    ref_sum = 0; ref_last = 0;
    #2;
    chk("reset_addr", bus.rom_addr, 0);
    chk("reset_data", bus.data_out, 0);
    chk("reset_sum", bus.sum, 0);
    chk("reset_valid", bus.data_valid, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    #10 reset = 1'b0;

    auto_scan(1'b0, -1);
    repeat (3) begin
      tick();
      idle_check("idle_hold");
    end
    step_scan(1'b0, -1);
    step_scan(1'b0, 2);
    auto_scan(1'b0, 2);
    auto_scan(1'b1, -1);
    step_scan(1'b1, -1);
    reset_midscan();
    auto_scan(1'b0, -1);

    for (int it = 0; it < 30; it++) begin
      load_rom(1'b0);
      mode = int'($urandom_range(0, 1));
      nz = 1'($urandom_range(0, 1));
      if (mode == 0) begin
        ab = int'($urandom_range(0, NW));
        auto_scan(nz, (ab == NW) ? -1 : ab);
      end else begin
        ab = int'($urandom_range(1, NW));
        step_scan(nz, (ab == NW) ? -1 : ab);
      end
      repeat (int'($urandom_range(0, 2))) begin
        tick();
        idle_check("rand_idle");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
